// File: rtl/sum_bcd_display.sv
// Captures a 5-bit adder result, converts it to BCD by double dabble,
// and scans it onto a 2-digit multiplexed 7-segment display.
module sum_bcd_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] S,
  input  logic       Co,
  input  logic       load,
  output logic       busy,
  output logic       ready,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      r_state;
  logic [4:0]  r_bin;
  logic [7:0]  r_scr;
  logic [2:0]  r_iter;
  logic        r_busy;
  logic        r_ready;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;

  logic [CW-1:0] r_cnt;
  logic          r_sel;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;

  logic [3:0] w_adj_hi;
  logic [3:0] w_adj_lo;
  logic [7:0] w_scr_nxt;
  logic [4:0] w_bin_nxt;
  logic [3:0] w_dig;
  logic [6:0] w_seg_hi;
  logic [1:0] w_an_hi;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // One double-dabble step: add-3 correction, then shift left.
  always_comb begin
    w_adj_hi  = r_scr[7:4];
    w_adj_lo  = r_scr[3:0];
    if (r_scr[7:4] >= 4'd5) w_adj_hi = r_scr[7:4] + 4'd3;
    if (r_scr[3:0] >= 4'd5) w_adj_lo = r_scr[3:0] + 4'd3;
    w_scr_nxt = {w_adj_hi[2:0], w_adj_lo, r_bin[4]};
    w_bin_nxt = {r_bin[3:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_scr   <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_tens  <= '0;
      r_units <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_bin   <= {Co, S};
            r_scr   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_scr  <= w_scr_nxt;
          r_bin  <= w_bin_nxt;
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'd4) begin
            r_tens  <= w_scr_nxt[7:4];
            r_units <= w_scr_nxt[3:0];
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Digit slot selection; a zero tens digit is blanked.
  always_comb begin
    w_dig    = r_sel ? r_tens : r_units;
    w_an_hi  = 2'b00;
    if (r_ready) begin
      if (!r_sel)
        w_an_hi = 2'b01;
      else if (r_tens != 4'd0)
        w_an_hi = 2'b10;
    end
    w_seg_hi = (w_an_hi != 2'b00) ? seg_pat(w_dig) : 7'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sel <= 1'b0;
      r_seg <= {7{COMMON_ANODE}};
      r_an  <= {2{COMMON_ANODE}};
    end else begin
      if (r_cnt == CW'(REFRESH_DIV - 1)) begin
        r_cnt <= '0;
        r_sel <= ~r_sel;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_seg <= w_seg_hi ^ {7{COMMON_ANODE}};
      r_an  <= w_an_hi ^ {2{COMMON_ANODE}};
    end
  end

  assign busy      = r_busy;
  assign ready     = r_ready;
  assign bcd_tens  = r_tens;
  assign bcd_units = r_units;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Bench for sum_bcd_display: vector table, scoreboard queue,
// and hand-written busy-load and mid-conversion reset sequences.
module tb_sum_bcd_display;

  logic       clk;
  logic       rst_n;
  logic [3:0] S;
  logic       Co;
  logic       load;
  logic       busy;
  logic       ready;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [6:0] seg;
  logic [1:0] an;

  sum_bcd_display #(
    .REFRESH_DIV (4),
    .COMMON_ANODE(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .S        (S),
    .Co       (Co),
    .load     (load),
    .busy     (busy),
    .ready    (ready),
    .bcd_tens (bcd_tens),
    .bcd_units(bcd_units),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       co;
    logic [3:0] s;
    int         tens;
    int         units;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] sb_q [$];
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_load(input logic co, input logic [3:0] s,
                            input int tens, input int units);
    @(negedge clk);
    Co   = co;
    S    = s;
    load = 1'b1;
    sb_q.push_back({4'(tens), 4'(units)});
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts busy cycles from the negedge after the load edge.
  task automatic wait_done(input string name, output int width);
    width = 0;
    while (busy && width < 20) begin
      width++;
      @(negedge clk);
    end
    chk({name, "_timeout"}, int'(width >= 20), 0);
  endtask

  task automatic check_result(input string name, input int width);
    logic [7:0] e;
    chk({name, "_busy_width"}, width, 5);
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_tens"}, int'(bcd_tens), int'(e[7:4]));
      chk({name, "_units"}, int'(bcd_units), int'(e[3:0]));
    end
    chk({name, "_ready"}, int'(ready), 1);
  endtask

  // Over 8 consecutive cycles each slot must last exactly 4 cycles.
  task automatic disp_chk(input string name, input int tens,
                          input int units);
    int u_n, o_n, err;
    u_n = 0; o_n = 0; err = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (an == 2'b10) begin
        u_n++;
        if (seg != ~pat[units]) err++;
      end else if (an == 2'b01) begin
        o_n++;
        if (tens == 0 || seg != ~pat[tens]) err++;
      end else if (an == 2'b11) begin
        o_n++;
        if (tens != 0 || seg != 7'h7F) err++;
      end else begin
        err++;
      end
      @(negedge clk);
    end
    chk({name, "_units_slot"}, u_n, 4);
    chk({name, "_tens_slot"}, o_n, 4);
    chk({name, "_seg_an"}, err, 0);
  endtask

  initial begin
    int w;
    int blank_err;
    vecs[0] = '{1'b1, 4'b1110, 3, 0};
    vecs[1] = '{1'b1, 4'b1111, 3, 1};
    vecs[2] = '{1'b0, 4'b0111, 0, 7};
    vecs[3] = '{1'b0, 4'b0000, 0, 0};
    vecs[4] = '{1'b1, 4'b0011, 1, 9};
    vecs[5] = '{1'b0, 4'b1010, 1, 0};

    rst_n = 1'b0; load = 1'b0; S = '0; Co = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_tens", int'(bcd_tens), 0);
    chk("rst_units", int'(bcd_units), 0);
    chk("rst_an", int'(an), 'h3);
    chk("rst_seg", int'(seg), 'h7F);
    rst_n = 1'b1;

    blank_err = 0;
    repeat (8) begin
      @(negedge clk);
      if (an != 2'b11 || seg != 7'h7F) blank_err++;
    end
    chk("not_ready_blank", blank_err, 0);

    foreach (vecs[i]) begin
      start_load(vecs[i].co, vecs[i].s, vecs[i].tens, vecs[i].units);
      wait_done($sformatf("vec%0d", i), w);
      check_result($sformatf("vec%0d", i), w);
      disp_chk($sformatf("vec%0d", i), vecs[i].tens, vecs[i].units);
    end

    // Second load two cycles into a conversion must be ignored.
    @(negedge clk);
    Co = 1'b0; S = 4'd9; load = 1'b1;
    sb_q.push_back(8'h09);
    @(negedge clk);
    load = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      w++;
      if (w == 2) begin
        Co = 1'b1; S = 4'd4; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    chk("busyload_timeout", int'(w >= 20), 0);
    check_result("busyload", w);
    @(negedge clk);
    chk("busyload_no_restart", int'(busy), 0);

    // Reset sampled on the third conversion edge aborts it.
    start_load(1'b1, 4'd9, 2, 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb_q.pop_back());
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_tens", int'(bcd_tens), 0);
    chk("midrst_units", int'(bcd_units), 0);
    chk("midrst_an", int'(an), 'h3);
    chk("midrst_seg", int'(seg), 'h7F);
    repeat (3) @(negedge clk);
    chk("midrst_stays_idle", int'(busy), 0);

    start_load(1'b1, 4'd9, 2, 5);
    wait_done("reload25", w);
    check_result("reload25", w);
    disp_chk("reload25", 2, 5);

    chk("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
